// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the two-port memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_id_t;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [3:0]  wmask;
    logic [31:0] address;
    logic [31:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/arb_grant_logic.sv
// rtl/arb_grant_logic.sv - combinational winner selection between port A and port B
module arb_grant_logic
  import mem_arb_pkg::*;
#(
  parameter int PRIORITY_MODE = 0,
  parameter int MAX_B_STREAK  = 4,
  parameter int STREAK_W      = 3
) (
  input  logic                a_req,
  input  logic                b_req,
  input  port_id_t            last_grant,
  input  logic [STREAK_W-1:0] streak,
  output logic                grant_valid,
  output port_id_t            grant
);

  always_comb begin
    grant_valid = a_req | b_req;
    grant       = PORT_A;
    if (a_req && b_req) begin
      if (PRIORITY_MODE == 0) begin
        grant = (last_grant == PORT_A) ? PORT_B : PORT_A;
      end else begin
        // B wins ties until it has starved A for MAX_B_STREAK grants in a row
        grant = (streak == STREAK_W'(MAX_B_STREAK)) ? PORT_A : PORT_B;
      end
    end else if (b_req) begin
      grant = PORT_B;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between an I-fetch port (A) and a data port (B)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int PRIORITY_MODE = 0,
  parameter int MAX_B_STREAK  = 4,
  parameter int TIMEOUT       = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_read,
  input  logic [31:0] a_address,
  output logic        a_resp,
  output logic [31:0] a_rdata,
  input  logic        b_read,
  input  logic        b_write,
  input  logic [3:0]  b_wmask,
  input  logic [31:0] b_address,
  input  logic [31:0] b_wdata,
  output logic        b_resp,
  output logic [31:0] b_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic        mem_resp,
  input  logic [31:0] mem_rdata,
  output logic        timeout_err
);

  localparam int STREAK_W = $clog2(MAX_B_STREAK + 1);
  localparam int TMO_W    = $clog2(TIMEOUT + 1);

  arb_state_t          state_q, state_d;
  mem_cmd_t            cmd_q, cmd_d;
  port_id_t            last_grant_q, last_grant_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic                timeout_err_q, timeout_err_d;

  logic     grant_valid;
  port_id_t grant;
  mem_cmd_t a_cmd, b_cmd;

  arb_grant_logic #(
    .PRIORITY_MODE (PRIORITY_MODE),
    .MAX_B_STREAK  (MAX_B_STREAK),
    .STREAK_W      (STREAK_W)
  ) u_grant (
    .a_req       (a_read),
    .b_req       (b_read | b_write),
    .last_grant  (last_grant_q),
    .streak      (streak_q),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  // A write wins over a simultaneous read on port B
  assign a_cmd = '{read: 1'b1, write: 1'b0, wmask: 4'b0000, address: a_address, wdata: 32'h0};
  assign b_cmd = '{read: b_read & ~b_write, write: b_write, wmask: b_wmask,
                   address: b_address, wdata: b_wdata};

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    last_grant_d  = last_grant_q;
    streak_d      = streak_q;
    tmo_cnt_d     = '0;
    timeout_err_d = timeout_err_q;
    a_resp        = 1'b0;
    b_resp        = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          if (grant == PORT_A) begin
            cmd_d    = a_cmd;
            state_d  = SERVE_A;
            streak_d = '0;
          end else begin
            cmd_d    = b_cmd;
            state_d  = SERVE_B;
            if (!a_read) begin
              streak_d = '0;
            end else if (streak_q != STREAK_W'(MAX_B_STREAK)) begin
              streak_d = streak_q + STREAK_W'(1);
            end
          end
        end
      end
      SERVE_A, SERVE_B: begin
        a_resp = (state_q == SERVE_A) & mem_resp;
        b_resp = (state_q == SERVE_B) & mem_resp;
        if (mem_resp) begin
          cmd_d.read   = 1'b0;
          cmd_d.write  = 1'b0;
          last_grant_d = (state_q == SERVE_A) ? PORT_A : PORT_B;
          state_d      = DONE;
        end else begin
          tmo_cnt_d = (tmo_cnt_q == TMO_W'(TIMEOUT)) ? tmo_cnt_q : tmo_cnt_q + TMO_W'(1);
          if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
            timeout_err_d = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cmd_q         <= '0;
      last_grant_q  <= PORT_B;
      streak_q      <= '0;
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      last_grant_q  <= last_grant_d;
      streak_q      <= streak_d;
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign mem_read    = cmd_q.read;
  assign mem_write   = cmd_q.write;
  assign mem_wmask   = cmd_q.wmask;
  assign mem_address = cmd_q.address;
  assign mem_wdata   = cmd_q.wdata;
  assign a_rdata     = mem_rdata;
  assign b_rdata     = mem_rdata;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench for mem_port_arbiter in round-robin and B-priority modes
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_read;
  logic [31:0] a_address;
  logic        b_read, b_write;
  logic [3:0]  b_wmask;
  logic [31:0] b_address, b_wdata;
  logic        mem_resp;
  logic [31:0] mem_rdata;

  logic        d0_a_resp, d0_b_resp, d0_mem_read, d0_mem_write, d0_timeout_err;
  logic [31:0] d0_a_rdata, d0_b_rdata, d0_mem_address, d0_mem_wdata;
  logic [3:0]  d0_mem_wmask;
  logic        d1_a_resp, d1_b_resp, d1_mem_read, d1_mem_write, d1_timeout_err;
  logic [31:0] d1_a_rdata, d1_b_rdata, d1_mem_address, d1_mem_wdata;
  logic [3:0]  d1_mem_wmask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.PRIORITY_MODE(0), .MAX_B_STREAK(4), .TIMEOUT(16)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .a_read(a_read), .a_address(a_address), .a_resp(d0_a_resp), .a_rdata(d0_a_rdata),
    .b_read(b_read), .b_write(b_write), .b_wmask(b_wmask), .b_address(b_address),
    .b_wdata(b_wdata), .b_resp(d0_b_resp), .b_rdata(d0_b_rdata),
    .mem_read(d0_mem_read), .mem_write(d0_mem_write), .mem_wmask(d0_mem_wmask),
    .mem_address(d0_mem_address), .mem_wdata(d0_mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata), .timeout_err(d0_timeout_err)
  );

  mem_port_arbiter #(.PRIORITY_MODE(1), .MAX_B_STREAK(4), .TIMEOUT(16)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .a_read(a_read), .a_address(a_address), .a_resp(d1_a_resp), .a_rdata(d1_a_rdata),
    .b_read(b_read), .b_write(b_write), .b_wmask(b_wmask), .b_address(b_address),
    .b_wdata(b_wdata), .b_resp(d1_b_resp), .b_rdata(d1_b_rdata),
    .mem_read(d1_mem_read), .mem_write(d1_mem_write), .mem_wmask(d1_mem_wmask),
    .mem_address(d1_mem_address), .mem_wdata(d1_mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata), .timeout_err(d1_timeout_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; a_read = 1'b0; a_address = '0; b_read = 1'b0; b_write = 1'b0;
    b_wmask = '0; b_address = '0; b_wdata = '0; mem_resp = 1'b0; mem_rdata = '0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (d0_mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read got %b exp 0", d0_mem_read); end
    checks++; if (d0_mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write got %b exp 0", d0_mem_write); end
    checks++; if (d0_mem_wmask !== 4'h0) begin errors++; $display("FAIL reset_mem_wmask got %h exp 0", d0_mem_wmask); end
    checks++; if (d0_mem_address !== 32'h0) begin errors++; $display("FAIL reset_mem_address got %h exp 0", d0_mem_address); end
    checks++; if (d0_mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata got %h exp 0", d0_mem_wdata); end
    checks++; if ({d0_a_resp, d0_b_resp, d0_timeout_err} !== 3'b000) begin errors++; $display("FAIL reset_resp_err got %b exp 000", {d0_a_resp, d0_b_resp, d0_timeout_err}); end
    checks++; if (d1_mem_read !== 1'b0 || d1_timeout_err !== 1'b0) begin errors++; $display("FAIL reset_dut1 got %b%b exp 00", d1_mem_read, d1_timeout_err); end
  endtask

  task automatic test_a_read();
    do_reset();
    a_read = 1'b1; a_address = 32'h60;
    tick();
    @(negedge clk);
    checks++; if (d0_mem_read !== 1'b1 || d0_mem_address !== 32'h60) begin errors++; $display("FAIL a_grant got rd=%b addr=%h exp rd=1 addr=60", d0_mem_read, d0_mem_address); end
    checks++; if (d0_mem_write !== 1'b0) begin errors++; $display("FAIL a_grant_write got %b exp 0", d0_mem_write); end
    checks++; if (d0_a_resp !== 1'b0) begin errors++; $display("FAIL a_early_resp got %b exp 0", d0_a_resp); end
    tick(); tick();
    mem_resp = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (d0_a_resp !== 1'b1 || d0_a_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL a_resp got resp=%b data=%h exp 1 deadbeef", d0_a_resp, d0_a_rdata); end
    checks++; if (d0_b_resp !== 1'b0 || d0_b_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL a_resp_b_side got resp=%b data=%h exp 0 deadbeef", d0_b_resp, d0_b_rdata); end
    tick();
    mem_resp = 1'b0; a_read = 1'b0;
    b_write = 1'b1; b_wmask = 4'hF; b_address = 32'h80; b_wdata = 32'h1;
    @(negedge clk);
    checks++; if (d0_a_resp !== 1'b0 || d0_mem_read !== 1'b0) begin errors++; $display("FAIL a_done got resp=%b rd=%b exp 0 0", d0_a_resp, d0_mem_read); end
    tick();
    @(negedge clk);
    checks++; if (d0_mem_write !== 1'b0) begin errors++; $display("FAIL done_ignores_req got wr=%b exp 0", d0_mem_write); end
    tick();
    @(negedge clk);
    checks++; if (d0_mem_write !== 1'b1 || d0_mem_address !== 32'h80) begin errors++; $display("FAIL regrant_latency got wr=%b addr=%h exp 1 80", d0_mem_write, d0_mem_address); end
    b_write = 1'b0;
  endtask

  task automatic test_b_write();
    do_reset();
    b_write = 1'b1; b_wmask = 4'b0110; b_address = 32'h1004; b_wdata = 32'h12345678;
    tick();
    @(negedge clk);
    checks++; if (d0_mem_write !== 1'b1 || d0_mem_read !== 1'b0) begin errors++; $display("FAIL b_strobes got wr=%b rd=%b exp 1 0", d0_mem_write, d0_mem_read); end
    checks++; if (d0_mem_wmask !== 4'b0110 || d0_mem_address !== 32'h1004 || d0_mem_wdata !== 32'h12345678) begin errors++; $display("FAIL b_cmd got m=%b a=%h d=%h exp 0110 1004 12345678", d0_mem_wmask, d0_mem_address, d0_mem_wdata); end
    tick();
    mem_resp = 1'b1;
    @(negedge clk);
    checks++; if (d0_b_resp !== 1'b1 || d0_a_resp !== 1'b0) begin errors++; $display("FAIL b_resp got b=%b a=%b exp 1 0", d0_b_resp, d0_a_resp); end
    tick();
    mem_resp = 1'b0; b_write = 1'b0;
    @(negedge clk);
    checks++; if (d0_b_resp !== 1'b0 || d0_mem_write !== 1'b0) begin errors++; $display("FAIL b_done got resp=%b wr=%b exp 0 0", d0_b_resp, d0_mem_write); end
    tick();
    b_read = 1'b1; b_write = 1'b1; b_wmask = 4'b0000; b_address = 32'h2002; b_wdata = 32'hA5A5A5A5;
    tick();
    @(negedge clk);
    checks++; if (d0_mem_write !== 1'b1 || d0_mem_read !== 1'b0 || d0_mem_wmask !== 4'b0000) begin errors++; $display("FAIL b_rw_decode got wr=%b rd=%b m=%b exp 1 0 0000", d0_mem_write, d0_mem_read, d0_mem_wmask); end
    checks++; if (d0_mem_address !== 32'h2002) begin errors++; $display("FAIL b_unaligned_addr got %h exp 2002", d0_mem_address); end
    b_read = 1'b0; b_write = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_addr [4];
    exp_addr[0] = 32'h100; exp_addr[1] = 32'h200; exp_addr[2] = 32'h100; exp_addr[3] = 32'h200;
    do_reset();
    a_read = 1'b1; a_address = 32'h100; b_read = 1'b1; b_address = 32'h200;
    for (int i = 0; i < 4; i++) begin
      logic is_a;
      int waited;
      is_a = (exp_addr[i] == 32'h100);
      waited = 0;
      @(negedge clk);
      while (d0_mem_read !== 1'b1 && waited < 10) begin @(negedge clk); waited++; end
      checks++; if (d0_mem_read !== 1'b1 || d0_mem_address !== exp_addr[i]) begin errors++; $display("FAIL rr_grant%0d got rd=%b addr=%h exp 1 %h", i, d0_mem_read, d0_mem_address, exp_addr[i]); end
      tick();
      mem_resp = 1'b1;
      @(negedge clk);
      checks++; if ((is_a ? d0_a_resp : d0_b_resp) !== 1'b1) begin errors++; $display("FAIL rr_resp%0d got a=%b b=%b exp granted port 1", i, d0_a_resp, d0_b_resp); end
      tick();
      mem_resp = 1'b0;
      if (is_a) a_read = 1'b0; else b_read = 1'b0;
      tick();
      a_read = 1'b1; b_read = 1'b1;
    end
    a_read = 1'b0; b_read = 1'b0;
  endtask

  task automatic test_starvation_guard();
    logic [31:0] exp_addr [6];
    exp_addr[0] = 32'h400; exp_addr[1] = 32'h400; exp_addr[2] = 32'h400;
    exp_addr[3] = 32'h400; exp_addr[4] = 32'h300; exp_addr[5] = 32'h400;
    do_reset();
    a_read = 1'b1; a_address = 32'h300; b_read = 1'b1; b_address = 32'h400;
    for (int i = 0; i < 6; i++) begin
      logic is_a;
      int waited;
      is_a = (exp_addr[i] == 32'h300);
      waited = 0;
      @(negedge clk);
      while (d1_mem_read !== 1'b1 && waited < 10) begin @(negedge clk); waited++; end
      checks++; if (d1_mem_read !== 1'b1 || d1_mem_address !== exp_addr[i]) begin errors++; $display("FAIL prio_grant%0d got rd=%b addr=%h exp 1 %h", i, d1_mem_read, d1_mem_address, exp_addr[i]); end
      tick();
      mem_resp = 1'b1;
      tick();
      mem_resp = 1'b0;
      if (is_a) a_read = 1'b0; else b_read = 1'b0;
      tick();
      a_read = 1'b1; b_read = 1'b1;
    end
    a_read = 1'b0; b_read = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    a_read = 1'b1; a_address = 32'h40;
    tick();
    repeat (15) tick();
    @(negedge clk);
    checks++; if (d0_timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_early got %b exp 0", d0_timeout_err); end
    tick();
    @(negedge clk);
    checks++; if (d0_timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_rise got %b exp 1", d0_timeout_err); end
    repeat (5) tick();
    mem_resp = 1'b1; mem_rdata = 32'hCAFE0001;
    @(negedge clk);
    checks++; if (d0_a_resp !== 1'b1 || d0_mem_read !== 1'b1) begin errors++; $display("FAIL tmo_late_resp got resp=%b rd=%b exp 1 1", d0_a_resp, d0_mem_read); end
    tick();
    mem_resp = 1'b0; a_read = 1'b0;
    @(negedge clk);
    checks++; if (d0_timeout_err !== 1'b1 || d0_mem_read !== 1'b0) begin errors++; $display("FAIL tmo_sticky got err=%b rd=%b exp 1 0", d0_timeout_err, d0_mem_read); end
    do_reset();
    @(negedge clk);
    checks++; if (d0_timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_clear got %b exp 0", d0_timeout_err); end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    b_read = 1'b1; b_address = 32'h2000;
    tick(); tick();
    rst_n = 1'b0; b_read = 1'b0;
    tick();
    rst_n = 1'b1; mem_resp = 1'b1;
    @(negedge clk);
    checks++; if ({d0_mem_read, d0_mem_write} !== 2'b00 || d0_mem_address !== 32'h0) begin errors++; $display("FAIL rst_mid_mem got rd=%b wr=%b addr=%h exp 0 0 0", d0_mem_read, d0_mem_write, d0_mem_address); end
    checks++; if (d0_b_resp !== 1'b0 || d0_a_resp !== 1'b0) begin errors++; $display("FAIL rst_mid_resp got b=%b a=%b exp 0 0", d0_b_resp, d0_a_resp); end
    tick();
    mem_resp = 1'b0;
    @(negedge clk);
    checks++; if (d0_b_resp !== 1'b0 || d0_mem_read !== 1'b0) begin errors++; $display("FAIL rst_mid_after got resp=%b rd=%b exp 0 0", d0_b_resp, d0_mem_read); end
  endtask

  initial begin
    test_reset();
    test_a_read();
    test_b_write();
    test_round_robin();
    test_starvation_guard();
    test_timeout();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
